// File: rtl/multicycle_main_control.sv
// ---------------------------------------------------------------------------
// multicycle_main_control
//
// Main control FSM for the multicycle MIPS datapath. It decodes IR[31:26] and
// steps each instruction through fetch, decode, execute, memory and writeback.
// It drives ALUop to the ALU control unit and receives that unit's Jr flag in
// return.
//
// Build option:
//   JAL_EN - when defined, opcode 000011 (jal) runs through a one-cycle JAL
//            state. When undefined, jal decodes as an illegal opcode.
//
// Parameter:
//   IDLE_ON_ILLEGAL - 1: an illegal opcode holds the FSM in ILLEGAL until reset
//                     0: Illegal pulses for one cycle, then the FSM refetches
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   Opcode         IR[31:26]
//   Jr             from ALU control; R-format instruction is jr
//   MemReady       memory handshake; the current access completes this cycle
//   ALUop          00 add, 01 sub, 10 R-format (funct), 11 and
//   ALUSrcA/B      ALU operand selects
//   ExtOp          1 = sign-extend, 0 = zero-extend
//   IorD           memory address select (PC / ALUOut)
//   MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite  strobes
//   RegDst         00 rt, 01 rd, 10 $31
//   MemtoReg       00 ALUOut, 01 MDR, 10 PC
//   PCSource       00 ALU, 01 ALUOut, 10 jump target, 11 register A
//   Illegal        unsupported opcode seen
//
// All outputs are decoded from the state register. The one exception is
// IRWrite/PCWrite in FETCH, which are also gated by MemReady. Every output is
// forced to 0 while rst_n is low.
// ---------------------------------------------------------------------------
module multicycle_main_control #(
    parameter bit IDLE_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       Jr,
    input  logic       MemReady,
    output logic [1:0] ALUop,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSource,
    output logic       Illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef JAL_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_R_WB,
        S_JR_DONE,
        S_BRANCH,
        S_I_EXEC,
        S_I_WB,
        S_JUMP,
        S_ILLEGAL
`ifdef JAL_EN
        , S_JAL
`endif
    } state_t;

    state_t state;
    state_t state_next;

    // The IR holds its value for the whole instruction, so I_WB decodes the
    // opcode again to keep the andi/addi ALU setting from I_EXEC.
    logic is_andi;
    assign is_andi = (Opcode == OP_ANDI);

    // NOTE: sequential state uses non-blocking assignment so that every
    // register samples its pre-edge value. This avoids race conditions
    // between always blocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: each combinational output gets a default before the case.
        // Any path that leaves a signal unassigned would otherwise infer a
        // latch.
        state_next  = state;
        ALUop       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ExtOp       = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        PCSource    = 2'b00;
        Illegal     = 1'b0;

        // With rst_n low the defaults stand. No strobe can fire on the
        // edge that aborts an instruction.
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                    if (MemReady) state_next = S_DECODE;
                end

                S_DECODE: begin
                    // Branch target PC + (imm << 2) is computed in advance.
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                    case (Opcode)
                        OP_RTYPE:      state_next = S_R_EXEC;
                        OP_LW, OP_SW:  state_next = S_MEM_ADDR;
                        OP_BEQ:        state_next = S_BRANCH;
                        OP_ADDI,
                        OP_ANDI:       state_next = S_I_EXEC;
                        OP_J:          state_next = S_JUMP;
`ifdef JAL_EN
                        OP_JAL:        state_next = S_JAL;
`endif
                        default:       state_next = S_ILLEGAL;
                    endcase
                end

                S_MEM_ADDR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ExtOp      = 1'b1;
                    state_next = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end

                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (MemReady) state_next = S_MEM_WB;
                end

                S_MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 2'b01;
                    state_next = S_FETCH;
                end

                S_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (MemReady) state_next = S_FETCH;
                end

                S_R_EXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUop      = 2'b10;
                    // The jr decision is taken here. It is held in the state
                    // register for the rest of the instruction.
                    state_next = Jr ? S_JR_DONE : S_R_WB;
                end

                S_R_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 2'b01;
                    state_next = S_FETCH;
                end

                S_JR_DONE: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b11;
                    state_next = S_FETCH;
                end

                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUop       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    state_next  = S_FETCH;
                end

                S_I_EXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUop      = is_andi ? 2'b11 : 2'b00;
                    ExtOp      = ~is_andi;
                    state_next = S_I_WB;
                end

                S_I_WB: begin
                    RegWrite   = 1'b1;
                    ALUop      = is_andi ? 2'b11 : 2'b00;
                    ExtOp      = ~is_andi;
                    state_next = S_FETCH;
                end

                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    state_next = S_FETCH;
                end

`ifdef JAL_EN
                S_JAL: begin
                    // PC already holds PC+4 from FETCH. That value goes to
                    // $31 while the PC loads the jump target.
                    RegWrite   = 1'b1;
                    RegDst     = 2'b10;
                    MemtoReg   = 2'b10;
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    state_next = S_FETCH;
                end
`endif

                S_ILLEGAL: begin
                    Illegal    = 1'b1;
                    state_next = IDLE_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
                end

                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_main_control
//
// Every instruction is expanded into its expected per-cycle control vectors.
// The expansion follows the instruction's step list: fetch with a number of
// wait cycles, decode, then the execute, memory and writeback steps. The
// memory steps also get wait cycles. Inputs that should have no effect in a
// given cycle are driven with random values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_main_control;

    localparam bit IDLE = 1'b1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] pcsource;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        ctrl_t      exp;
        bit         rst_n;
        bit         mr;
        bit         jr;
        logic [5:0] op;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Opcode = '0;
    logic       Jr = 1'b0;
    logic       MemReady = 1'b0;
    logic [1:0] ALUop, ALUSrcB, RegDst, MemtoReg, PCSource;
    logic       ALUSrcA, ExtOp, IorD, MemRead, MemWrite, IRWrite, PCWrite;
    logic       PCWriteCond, RegWrite, Illegal;

    int vectors = 0;
    int miscompares = 0;
    step_t q[$];

    always #5 clk = ~clk;

    multicycle_main_control #(.IDLE_ON_ILLEGAL(IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Jr(Jr), .MemReady(MemReady),
        .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSource(PCSource), .Illegal(Illegal)
    );

    ctrl_t got_w;
    assign got_w = {ALUop, ALUSrcA, ALUSrcB, ExtOp, IorD, MemRead, MemWrite,
                    IRWrite, PCWrite, PCWriteCond, RegWrite, RegDst, MemtoReg,
                    PCSource, Illegal};

    // ---------------- expected control vector per instruction step --------
    function automatic ctrl_t c_fetch(bit mr);
        ctrl_t c = '0;
        c.memread = 1'b1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr;
        return c;
    endfunction
    function automatic ctrl_t c_decode();
        ctrl_t c = '0;
        c.alusrcb = 2'b11; c.extop = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_memaddr();
        ctrl_t c = '0;
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.extop = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t c_memaccess(bit wr);
        ctrl_t c = '0;
        c.iord = 1'b1; c.memread = ~wr; c.memwrite = wr;
        return c;
    endfunction
    function automatic ctrl_t c_writeback(logic [1:0] dst, logic [1:0] src);
        ctrl_t c = '0;
        c.regwrite = 1'b1; c.regdst = dst; c.memtoreg = src;
        return c;
    endfunction
    function automatic ctrl_t c_rexec();
        ctrl_t c = '0;
        c.alusrca = 1'b1; c.aluop = 2'b10;
        return c;
    endfunction
    function automatic ctrl_t c_pcload(logic [1:0] src);
        ctrl_t c = '0;
        c.pcwrite = 1'b1; c.pcsource = src;
        return c;
    endfunction
    function automatic ctrl_t c_branch();
        ctrl_t c = '0;
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1; c.pcsource = 2'b01;
        return c;
    endfunction
    function automatic ctrl_t c_iexec(bit andi);
        ctrl_t c = '0;
        c.alusrca = 1'b1; c.alusrcb = 2'b10;
        c.aluop = andi ? 2'b11 : 2'b00; c.extop = ~andi;
        return c;
    endfunction
    function automatic ctrl_t c_iwb(bit andi);
        ctrl_t c = c_writeback(2'b00, 2'b00);
        c.aluop = andi ? 2'b11 : 2'b00; c.extop = ~andi;
        return c;
    endfunction
    function automatic ctrl_t c_jal();
        ctrl_t c = c_writeback(2'b10, 2'b10);
        c.pcwrite = 1'b1; c.pcsource = 2'b10;
        return c;
    endfunction
    function automatic ctrl_t c_illegal();
        ctrl_t c = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(1, 0));
    endfunction

    task automatic push(input ctrl_t c, input bit rst, input bit mr, input bit jr,
                        input logic [5:0] op);
        step_t s;
        s.exp = c; s.rst_n = rst; s.mr = mr; s.jr = jr; s.op = op;
        q.push_back(s);
    endtask

    task automatic push_reset(input bit mr);
        push('0, 1'b0, mr, rb(), 6'($urandom));
    endtask

    // Expand one instruction into expected cycles. fw is the number of fetch
    // wait cycles and mw the number of memory wait cycles.
    task automatic add_instr(input logic [5:0] op, input bit jr, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(c_fetch(1'b0), 1'b1, 1'b0, rb(), 6'($urandom));
        push(c_fetch(1'b1), 1'b1, 1'b1, rb(), 6'($urandom));
        push(c_decode(), 1'b1, rb(), rb(), op);
        case (op)
            OP_R: begin
                push(c_rexec(), 1'b1, rb(), jr, op);
                if (jr) push(c_pcload(2'b11), 1'b1, rb(), rb(), op);
                else    push(c_writeback(2'b01, 2'b00), 1'b1, rb(), rb(), op);
            end
            OP_LW, OP_SW: begin
                push(c_memaddr(), 1'b1, rb(), rb(), op);
                for (int i = 0; i < mw; i++)
                    push(c_memaccess(op == OP_SW), 1'b1, 1'b0, rb(), op);
                push(c_memaccess(op == OP_SW), 1'b1, 1'b1, rb(), op);
                if (op == OP_LW) push(c_writeback(2'b00, 2'b01), 1'b1, rb(), rb(), op);
            end
            OP_BEQ: push(c_branch(), 1'b1, rb(), rb(), op);
            OP_ADDI, OP_ANDI: begin
                push(c_iexec(op == OP_ANDI), 1'b1, rb(), rb(), op);
                push(c_iwb(op == OP_ANDI), 1'b1, rb(), rb(), op);
            end
            OP_J: push(c_pcload(2'b10), 1'b1, rb(), rb(), op);
`ifdef JAL_EN
            OP_JAL: push(c_jal(), 1'b1, rb(), rb(), op);
`endif
            default: begin
                push(c_illegal(), 1'b1, rb(), rb(), op);
                if (IDLE)
                    for (int i = 0; i < 11; i++) push(c_illegal(), 1'b1, rb(), rb(), op);
            end
        endcase
    endtask

    // Drive one cycle's inputs on the falling edge and sample just after.
    task automatic apply(input step_t s, output ctrl_t got);
        @(negedge clk);
        rst_n = s.rst_n; MemReady = s.mr; Jr = s.jr; Opcode = s.op;
        #1;
        got = got_w;
    endtask

    // ---------------- tests ------------------------------------------------
    task automatic test_reset();
        step_t s; ctrl_t got; int idx = 0;
        push_reset(1'b1);
        push_reset(1'b1);
        while (q.size() > 0) begin
            s = q.pop_front(); apply(s, got); vectors++;
            if (got !== s.exp) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %h expected %h", idx, got, s.exp);
            end
            idx++;
        end
    endtask

    task automatic test_rformat();
        step_t s; ctrl_t got; int idx = 0;
        add_instr(OP_R, 1'b0, 0, 0);
        push(c_fetch(1'b0), 1'b1, 1'b0, rb(), 6'($urandom));
        while (q.size() > 0) begin
            s = q.pop_front(); apply(s, got); vectors++;
            if (got !== s.exp) begin
                miscompares++;
                $display("FAIL rformat[%0d]: got %h expected %h", idx, got, s.exp);
            end
            idx++;
        end
    endtask

    task automatic test_lw_wait();
        step_t s; ctrl_t got; int idx = 0;
        add_instr(OP_LW, 1'b0, 0, 3);
        while (q.size() > 0) begin
            s = q.pop_front(); apply(s, got); vectors++;
            if (got !== s.exp) begin
                miscompares++;
                $display("FAIL lw_wait[%0d]: got %h expected %h", idx, got, s.exp);
            end
            idx++;
        end
    endtask

    task automatic test_andi_beq();
        step_t s; ctrl_t got; int idx = 0;
        add_instr(OP_ANDI, 1'b0, 0, 0);
        add_instr(OP_BEQ, 1'b0, 0, 0);
        add_instr(OP_ADDI, 1'b0, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front(); apply(s, got); vectors++;
            if (got !== s.exp) begin
                miscompares++;
                $display("FAIL andi_beq[%0d]: got %h expected %h", idx, got, s.exp);
            end
            idx++;
        end
    endtask

    task automatic test_jr();
        step_t s; ctrl_t got; int idx = 0;
        add_instr(OP_R, 1'b1, 0, 0);
        add_instr(OP_R, 1'b1, 2, 0);
        while (q.size() > 0) begin
            s = q.pop_front(); apply(s, got); vectors++;
            if (got !== s.exp) begin
                miscompares++;
                $display("FAIL jr[%0d]: got %h expected %h", idx, got, s.exp);
            end
            idx++;
        end
    endtask

    task automatic test_random();
        step_t s; ctrl_t got; int idx = 0;
        logic [5:0] op; bit jr;
        for (int n = 0; n < 60; n++) begin
            jr = 1'b0;
            case ($urandom_range(7, 0))
                0: op = OP_R;
                1: begin op = OP_R; jr = 1'b1; end
                2: op = OP_LW;
                3: op = OP_SW;
                4: op = OP_BEQ;
                5: op = OP_ADDI;
                6: op = OP_ANDI;
                default: op = OP_J;
            endcase
            add_instr(op, jr, $urandom_range(3, 0), $urandom_range(3, 0));
        end
        while (q.size() > 0) begin
            s = q.pop_front(); apply(s, got); vectors++;
            if (got !== s.exp) begin
                miscompares++;
                $display("FAIL random[%0d] op=%b: got %h expected %h", idx, s.op, got, s.exp);
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid_sw();
        step_t s; ctrl_t got; int idx = 0;
        add_instr(OP_SW, 1'b0, 0, 2);
        void'(q.pop_back());                 // abort before the access completes
        push_reset(1'b0);
        push(c_fetch(1'b0), 1'b1, 1'b0, rb(), 6'($urandom));
        add_instr(OP_SW, 1'b0, 1, 1);
        while (q.size() > 0) begin
            s = q.pop_front(); apply(s, got); vectors++;
            if (got !== s.exp) begin
                miscompares++;
                $display("FAIL reset_mid_sw[%0d]: got %h expected %h", idx, got, s.exp);
            end
            idx++;
        end
    endtask

    task automatic test_illegal();
        step_t s; ctrl_t got; int idx = 0;
        add_instr(OP_BAD, 1'b0, 0, 0);
        push_reset(1'b1);
        push(c_fetch(1'b0), 1'b1, 1'b0, rb(), 6'($urandom));
        add_instr(OP_JAL, 1'b0, 0, 0);       // jal, or illegal when JAL_EN is off
        push_reset(1'b0);
        add_instr(OP_R, 1'b0, 0, 0);
        while (q.size() > 0) begin
            s = q.pop_front(); apply(s, got); vectors++;
            if (got !== s.exp) begin
                miscompares++;
                $display("FAIL illegal[%0d]: got %h expected %h", idx, got, s.exp);
            end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_rformat();
        test_lw_wait();
        test_andi_beq();
        test_jr();
        test_random();
        test_reset_mid_sw();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
